// File: rtl/write_back.sv
// ============================================================================
//  Module      : write_back
//  Description : Write-back stage of the 5-stage 32-bit RISC pipeline.
//                Selects between the ALU result and the data-memory read
//                data and registers the selection. The registered value is
//                the register-file write data used in the decode stage.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1           pipeline clock, rising-edge active
//    reset        in   1           synchronous active-high reset
//    wb_en        in   1           source select: 1 = MemoryData, 0 = alu_result
//    alu_result   in   DATA_WIDTH  execute-stage result via MEM/WB boundary
//    MemoryData   in   DATA_WIDTH  data-memory read data
//    RegWriteData out  DATA_WIDTH  registered write-back data
// ============================================================================
`default_nettype none

module write_back #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_en,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] MemoryData,
    output logic [DATA_WIDTH-1:0] RegWriteData
);

    logic [DATA_WIDTH-1:0] RegWriteData_d;
    logic [DATA_WIDTH-1:0] RegWriteData_q;

    // Explicit if/else select so an unknown value on the unselected input
    // can never leak into the result.
    always_comb begin
        RegWriteData_d = alu_result;
        if (reset) begin
            RegWriteData_d = '0;
        end else if (wb_en) begin
            RegWriteData_d = MemoryData;
        end else begin
            RegWriteData_d = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        RegWriteData_q <= RegWriteData_d;
    end

    // Output comes straight from the register: no input-to-output comb path.
    assign RegWriteData = RegWriteData_q;

endmodule

`default_nettype wire

// File: tb/tb_write_back.sv
// ============================================================================
//  Module      : tb_write_back
//  Description : Self-checking bench for write_back. A driver issues
//                directed and random vectors and pushes the expected output
//                into a queue; a monitor pops and compares one clock later.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_write_back;

    localparam int DATA_WIDTH = 32;

    logic                  clk;
    logic                  reset;
    logic                  wb_en;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] MemoryData;
    logic [DATA_WIDTH-1:0] RegWriteData;

    logic [DATA_WIDTH-1:0] exp_q[$];
    string                 name_q[$];
    int                    vectors;
    int                    miscompares;

    write_back #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_en        (wb_en),
        .alu_result   (alu_result),
        .MemoryData   (MemoryData),
        .RegWriteData (RegWriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the register takes zero under reset, otherwise the selected
    // source, and presents it after exactly one edge.
    function automatic logic [DATA_WIDTH-1:0] ref_model(
        input logic rst, input logic sel,
        input logic [DATA_WIDTH-1:0] alu, input logic [DATA_WIDTH-1:0] mem);
        if (rst)      return '0;
        else if (sel) return mem;
        else          return alu;
    endfunction

    // Drive between edges, then record the expectation at the sampling edge.
    task automatic apply(input string nm, input logic rst, input logic sel,
                         input logic [DATA_WIDTH-1:0] alu,
                         input logic [DATA_WIDTH-1:0] mem);
        @(negedge clk);
        reset      = rst;
        wb_en      = sel;
        alu_result = alu;
        MemoryData = mem;
        @(posedge clk);
        exp_q.push_back(ref_model(rst, sel, alu, mem));
        name_q.push_back(nm);
    endtask

    // Monitor: output is stable 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [DATA_WIDTH-1:0] e;
            string                 n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            vectors++;
            if (RegWriteData !== e) begin
                miscompares++;
                $display("FAIL %s: RegWriteData=0x%08h expected 0x%08h at %0t",
                         n, RegWriteData, e, $time);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        wb_en       = 1'b0;
        alu_result  = '0;
        MemoryData  = '0;

        // Reset held for three edges with wb_en toggling.
        apply("reset0", 1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF);
        apply("reset1", 1'b1, 1'b1, 32'h12345678, 32'hDEADBEEF);
        apply("reset2", 1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF);

        // ALU path with memory data churning.
        for (int i = 0; i < 6; i++)
            apply("alu_path", 1'b0, 1'b0, 32'(i), $urandom);

        // Memory path.
        apply("mem_path", 1'b0, 1'b1, 32'h11111111, 32'hA5A5A5A5);
        apply("mem_path", 1'b0, 1'b1, 32'h11111111, 32'h0000FFFF);

        // Select switching on consecutive edges.
        apply("sel_sw", 1'b0, 1'b0, 32'h5, 32'h9);
        apply("sel_sw", 1'b0, 1'b1, 32'h5, 32'h9);
        apply("sel_sw", 1'b0, 1'b0, 32'h5, 32'h9);

        // Reset in mid-operation, then release.
        apply("mid_run",   1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
        apply("mid_reset", 1'b1, 1'b1, 32'h0, 32'hCAFEF00D);
        apply("mid_rel",   1'b0, 1'b1, 32'h0, 32'hCAFEF00D);

        // Width boundary.
        apply("width", 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0);
        apply("width", 1'b0, 1'b0, 32'h80000000, 32'h0);
        apply("width", 1'b0, 1'b1, 32'h0, 32'hFFFFFFFF);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 300; i++)
            apply("random", ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
                  $urandom, $urandom);

        // Drain, and treat any expectation never checked as a miscompare.
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/write_back.md
Name: write_back

Overview:
Write-back stage of the 5-stage 32-bit RISC pipeline. Selects between the ALU result and the data-memory read data, and registers the choice. The registered value drives RegWriteData, the register-file write-data input in the decode stage. Sits after the MEM/WB pipeline boundary; one register stage, no stalls.

Parameters:
DATA_WIDTH, 32, width of alu_result, MemoryData and RegWriteData.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
wb_en  input  1  write-back source select: 1 = MemoryData (load), 0 = alu_result (ALU op).
alu_result  input  DATA_WIDTH  result from execute stage, forwarded through the MEM/WB boundary.
MemoryData  input  DATA_WIDTH  data read from data memory.
RegWriteData  output  DATA_WIDTH  registered write-back data to the register file.

Behaviour:
- Single output register RegWriteData_q. RegWriteData is driven directly from it, with no combinational path from the inputs.
- On each rising edge of clk:
  - reset == 1: RegWriteData_q <= 0.
  - else if wb_en == 1: RegWriteData_q <= MemoryData.
  - else: RegWriteData_q <= alu_result.
- Latency: exactly 1 clock from the sampled inputs to RegWriteData. Throughput is 1 value per clock. There is no handshake.
- Reset value: RegWriteData = 0 (all DATA_WIDTH bits).
- Reset is synchronous. Asserting reset between edges has no effect until the next rising edge. Reset has priority over wb_en and the data inputs at the same edge.
- Reset held high for multiple cycles: the output stays 0 regardless of input activity.
- Deassertion: on the first edge with reset == 0, the output loads the selected input. There is no extra warm-up cycle.
- The mux is a pure bitwise pass-through. There is no arithmetic, sign extension or truncation, and all DATA_WIDTH bits are copied unchanged (e.g. 0xFFFFFFFF passes as is).
- A wb_en toggle takes effect at the next edge. The unselected input is ignored completely.
- X/Z on the unselected input must not propagate to the output. The implementation uses an explicit if/else or case, not an arithmetic blend.
- No internal state other than the output register. No asynchronous logic. Fully synthesizable, with no latches.
- Optional assertion (simulation only): after any edge with reset high, RegWriteData == 0 one delta later.

Test Plan:
- Reset: hold reset=1 for 3 clocks with alu_result=0x12345678, MemoryData=0xDEADBEEF, wb_en toggling -> RegWriteData stays 0x00000000 throughout.
- ALU path: reset=0, wb_en=0, alu_result increments 0,1,2,... each clock -> RegWriteData equals the previous cycle's alu_result (0,1,2,... lagging by one clock); MemoryData changes have no effect.
- Memory path: wb_en=1, MemoryData=0xA5A5A5A5 then 0x0000FFFF, alu_result=0x11111111 -> RegWriteData = 0xA5A5A5A5, then 0x0000FFFF, one clock after each is applied.
- Select switch: alu_result=0x00000005, MemoryData=0x00000009, flip wb_en 0->1->0 on consecutive edges -> RegWriteData sequence 5, 9, 5, each one clock later.
- Reset mid-operation: running with wb_en=1, MemoryData=0xCAFEF00D; assert reset for one edge, then release -> RegWriteData = 0 after that edge and 0xCAFEF00D on the next edge.
- Width boundary: wb_en=0, alu_result=0xFFFFFFFF, then 0x80000000 -> RegWriteData = 0xFFFFFFFF, then 0x80000000 (no sign or width corruption).
